// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: writable program store with a step-driven fetch sequencer.
// The fetch address comes from the switches (manual mode) or from the internal
// program counter (auto-run mode). A branch-on-board-number word is followed
// once in hardware before the result is offered to decode.
//
// Output handshake: o_rd_valid rises when a new word is loaded into o_rd.
// o_rd is then held, and o_rd_valid stays high, until a clock edge that sees
// i_rd_ready=1. That edge completes the transfer.
module instr_fetch_seq #(
    parameter int WIDTH     = 32,
    parameter int AW        = 3,
    parameter int SW_W      = 4,
    parameter int BOARD_NUM = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mode,
    input  logic [AW-1:0]    i_asw,
    input  logic [SW_W-1:0]  i_beq_sw,
    input  logic             i_step,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [AW-1:0]    o_pc,
    output logic             o_br_taken,
    output logic [1:0]       o_state
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_step_q;
    logic             r_rise_q;
    logic [AW-1:0]    r_addr;
    logic             r_mode_q;
    logic [WIDTH-1:0] r_rd;
    logic             r_rd_valid;
    logic [AW-1:0]    r_pc;
    logic             r_br_taken;

    logic             w_step_rise;
    logic [WIDTH-1:0] w_word;
    logic             w_is_branch;
    logic             w_taken;
    logic [AW-1:0]    w_addr_nxt;
    logic             w_mode_nxt;
    logic [WIDTH-1:0] w_rd_nxt;
    logic             w_valid_nxt;
    logic [AW-1:0]    w_pc_nxt;
    logic             w_br_nxt;

    // A rise is only latched while idle, so pulses arriving mid-fetch are dropped.
    assign w_step_rise = i_step & ~r_step_q;
    assign w_word      = r_mem[r_addr];
    assign w_is_branch = (w_word[WIDTH-1 -: 6] == 6'd0) && (w_word[AW-1:0] != '0);
    assign w_taken     = (i_beq_sw == SW_W'(BOARD_NUM));

    // Program store: cleared on reset, written on any cycle; reads see the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Step edge detector with a one-cycle registered rise that starts the fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_q <= 1'b0;
            r_rise_q <= 1'b0;
        end else begin
            r_step_q <= i_step;
            r_rise_q <= w_step_rise && (r_state == ST_IDLE);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (r_rise_q) w_state_nxt = ST_FETCH;
            ST_FETCH:   w_state_nxt = w_is_branch ? ST_RESOLVE : ST_HOLD;
            ST_RESOLVE: w_state_nxt = ST_HOLD;
            ST_HOLD:    if (i_rd_ready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath next values per state; mode is captured at fetch start for the pc update.
    always_comb begin
        w_addr_nxt  = r_addr;
        w_mode_nxt  = r_mode_q;
        w_rd_nxt    = r_rd;
        w_valid_nxt = r_rd_valid;
        w_pc_nxt    = r_pc;
        w_br_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rise_q) begin
                    w_addr_nxt = i_mode ? r_pc : i_asw;
                    w_mode_nxt = i_mode;
                end
            end
            ST_FETCH: begin
                if (w_is_branch) begin
                    w_addr_nxt = w_taken ? w_word[AW-1:0] : '0;
                    w_br_nxt   = w_taken;
                end else begin
                    w_rd_nxt    = w_word;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_RESOLVE: begin
                w_rd_nxt    = w_word;
                w_valid_nxt = 1'b1;
            end
            ST_HOLD: begin
                if (i_rd_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_mode_q) w_pc_nxt = r_addr + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_mode_q   <= 1'b0;
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
            r_pc       <= '0;
            r_br_taken <= 1'b0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_mode_q   <= w_mode_nxt;
            r_rd       <= w_rd_nxt;
            r_rd_valid <= w_valid_nxt;
            r_pc       <= w_pc_nxt;
            r_br_taken <= w_br_nxt;
        end
    end

    assign o_rd       = r_rd;
    assign o_rd_valid = r_rd_valid;
    assign o_pc       = r_pc;
    assign o_br_taken = r_br_taken;
    assign o_state    = r_state;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: expected words are queued at each step
// and compared when rd_valid appears.
module tb_instr_fetch_seq;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [2:0]  asw;
    logic [3:0]  beq_sw;
    logic        step;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rd;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  pc;
    logic        br_taken;
    logic [1:0]  state;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    instr_fetch_seq #(.WIDTH(32), .AW(3), .SW_W(4), .BOARD_NUM(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_mode     (mode),
        .i_asw      (asw),
        .i_beq_sw   (beq_sw),
        .i_step     (step),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_rd       (rd),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_pc       (pc),
        .o_br_taken (br_taken),
        .o_state    (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // One step pulse; expected word queued, latency / branch pulse / data checked.
    task automatic do_fetch(input logic [31:0] exp_rd, input int exp_lat,
                            input int exp_br, input string tag);
        int lat;
        int br_cnt;
        bit seen;
        logic [31:0] e;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        lat = 0; br_cnt = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (br_taken) br_cnt++;
            if (rd_valid) seen = 1'b1;
        end
        chk({tag, "_valid"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_br"}, br_cnt, exp_br);
        e = exp_q.pop_front();
        chk({tag, "_rd"}, rd, e);
        if (rd_ready) begin
            @(posedge clk); #1;
            chk({tag, "_vdrop"}, 32'(rd_valid), 32'd0);
            chk({tag, "_idle"}, 32'(state), 32'd0);
            chk({tag, "_rdkeep"}, rd, e);
        end
    endtask

    initial begin
        logic [31:0] e;
        rst = 1'b0; mode = 1'b0; asw = '0; beq_sw = '0; step = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", rd, 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_br", 32'(br_taken), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // taken branch: address 5 holds a branch to 1
        wr_word(3'd1, 32'h5400_7002);
        wr_word(3'd5, 32'h0000_0001);
        beq_sw = 4'd2; mode = 1'b0; asw = 3'd5;
        do_fetch(32'h5400_7002, 3, 1, "br_taken");
        chk("br_taken_pc", 32'(pc), 32'd0);

        // not taken: falls back to address 0
        beq_sw = 4'd3;
        do_fetch(32'h0000_0000, 3, 0, "br_not");
        chk("br_not_pc", 32'(pc), 32'd0);

        // auto-run over the whole program, then wrap
        mode = 1'b1;
        for (int i = 0; i < 8; i++) wr_word(3'(i), 32'h1111_1111 * (i + 1));
        for (int i = 0; i < 8; i++) begin
            do_fetch(32'h1111_1111 * (i + 1), 2, 0, $sformatf("auto%0d", i));
            chk($sformatf("auto%0d_pc", i), 32'(pc), (i + 1) % 8);
        end
        do_fetch(32'h1111_1111, 2, 0, "wrap");
        chk("wrap_pc", 32'(pc), 32'd1);

        // back-pressure: output held, step pulses ignored
        rd_ready = 1'b0;
        do_fetch(32'h2222_2222, 2, 0, "hold");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            step = (k == 1 || k == 3);
            @(posedge clk); #1;
            chk("hold_rd", rd, 32'h2222_2222);
            chk("hold_valid", 32'(rd_valid), 32'd1);
            chk("hold_pc", 32'(pc), 32'd1);
        end
        @(negedge clk);
        step = 1'b0; rd_ready = 1'b1;
        @(posedge clk); #1;
        chk("acc_valid", 32'(rd_valid), 32'd0);
        chk("acc_pc", 32'(pc), 32'd2);
        repeat (3) begin
            @(posedge clk); #1;
            chk("acc_noqueue", 32'(state), 32'd0);
        end
        chk("acc_pc_once", 32'(pc), 32'd2);

        // write to address 3 on the same edge that reads it
        mode = 1'b0; asw = 3'd3;
        wr_word(3'd3, 32'h1111_1111);
        exp_q.push_back(32'h1111_1111);
        @(negedge clk); step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        @(posedge clk); #1;
        chk("rbw_fetch_state", 32'(state), 32'd1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("rbw_valid", 32'(rd_valid), 32'd1);
        e = exp_q.pop_front();
        chk("rbw_rd", rd, e);
        @(posedge clk); #1;
        do_fetch(32'hAAAA_AAAA, 2, 0, "rbw_new");
        chk("rbw_pc", 32'(pc), 32'd2);

        // reset during RESOLVE
        beq_sw = 4'd2;
        wr_word(3'd6, 32'h0000_0002);
        asw = 3'd6;
        @(negedge clk); step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_state", 32'(state), 32'd2);
        chk("mid_br", 32'(br_taken), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_br", 32'(br_taken), 32'd0);
        chk("mid_rst_rd", rd, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        asw = 3'd3;
        do_fetch(32'h0, 2, 0, "clr3");
        asw = 3'd7;
        do_fetch(32'h0, 2, 0, "clr7");
        asw = 3'd6;
        do_fetch(32'h0, 2, 0, "clr6");
        mode = 1'b1;
        do_fetch(32'h0, 2, 0, "clr_auto");
        chk("clr_auto_pc", 32'(pc), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Parametrised instruction store and fetch sequencer for the switch-driven single-cycle CPU demo. It holds a writable program of `DEPTH` words and fetches one instruction per `step` pulse. The address comes from the board switches (manual mode) or from an internal program counter (auto-run mode). It resolves the branch-on-board-number pseudo-instruction in hardware and presents the result on a valid/ready output toward the decode stage.

## Interface
- `WIDTH`, 32: instruction word width (≥ 6 + `AW`).
- `AW`, 3: address width; `DEPTH` = 2**`AW` words.
- `SW_W`, 4: width of branch-condition switch input.
- `BOARD_NUM`, 2: value `beq_sw` must equal for a branch to be taken.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mode` in 1: 0 = manual (address from `asw`), 1 = auto-run (address from `pc`).
- `asw` in `AW`: manual fetch address from switches.
- `beq_sw` in `SW_W`: branch-condition switches.
- `step` in 1: fetch request; its rising edge is detected internally.
- `wr_en` in 1: program-load write strobe.
- `wr_addr` in `AW`: program-load address.
- `wr_data` in `WIDTH`: program-load data.
- `rd` out `WIDTH`: fetched instruction.
- `rd_valid` out 1: `rd` holds a new instruction.
- `rd_ready` in 1: consumer accepts `rd`.
- `pc` out `AW`: program counter (auto mode).
- `br_taken` out 1: one-cycle pulse when a fetched branch was taken.

## Operation
- Storage: `DEPTH` × `WIDTH` register array. Reset clears every word to 0 (NOP).
- Writes: when `wr_en`=1, `mem[wr_addr]` <= `wr_data` on the clock edge. Writes are accepted in any state.
- Same-cycle read and write of one address returns the old data (read-before-write).
- Branch word: `word[WIDTH-1:WIDTH-6]`==0 and `word[AW-1:0]`!=0. Target = `word[AW-1:0]`.
  - Taken when `beq_sw`==`BOARD_NUM`; otherwise fetch goes to address 0.
  - Only one branch is followed per fetch. If the resolved word is itself a branch, it is output as-is.
- Step detect: `step_q` register (reset 0). `step_rise` = `step` & ~`step_q`.
- FSM states: IDLE, FETCH, RESOLVE, HOLD. Reset state is IDLE.
  - IDLE: on `step_rise`, `addr` <= (`mode` ? `pc` : `asw`); go to FETCH. Otherwise stay.
  - FETCH: read `mem[addr]`.
    - If branch: `addr` <= taken ? target : 0; `br_taken` <= taken; go to RESOLVE.
    - Else: `rd` <= word; `rd_valid` <= 1; go to HOLD.
  - RESOLVE: `rd` <= `mem[addr]`; `rd_valid` <= 1; go to HOLD.
  - HOLD: hold `rd` and `rd_valid`=1 until `rd_ready`=1.
    - On acceptance: `rd_valid` <= 0; if `mode`=1, `pc` <= `addr`+1 (wraps `DEPTH`-1 → 0); go to IDLE.
    - `rd` keeps its value after acceptance.
- `step` rising edges outside IDLE are ignored; they are not queued.
- `mode` and `asw` are sampled only at the IDLE→FETCH transition. A change mid-fetch affects the next fetch only.
- `pc` is not changed by manual-mode fetches.

## Timing
- Reset values: `rd`=0, `rd_valid`=0, `pc`=0, `br_taken`=0, state IDLE, all words 0. Reset asserted mid-fetch aborts immediately to these values.
- `step_rise` seen at edge t → FETCH at t+1.
- Non-branch: `rd_valid`=1 after edge t+2 (latency 2). Branch: `rd_valid`=1 after edge t+3 (latency 3).
- `br_taken` is high for exactly the cycle after FETCH, i.e. during RESOLVE.
- With `rd_ready` held high: `rd_valid` is high for exactly one cycle; IDLE is reached one edge later. A new `step_rise` is accepted from that IDLE cycle onward.
- `rd_valid` never drops without `rd_ready`=1. `rd` is stable while `rd_valid`=1.

## Test plan
- Reset, then write `mem[1]`=0x5400_7002, `mem[5]`=0x0000_0001, `beq_sw`=2, `mode`=0, `asw`=5, `rd_ready`=1, step → `rd`=0x5400_7002 three cycles after the step edge; `br_taken` pulses; `pc` stays 0.
- Same setup, `beq_sw`=3 → `rd`=0 (word 0); `br_taken` stays 0.
- `mode`=1, write distinct non-branch words to 0..7, eight steps → `rd` sequence words 0..7, each at latency 2. Ninth step → word 0 (`pc` wraps).
- `rd_ready`=0 for 5 cycles after `rd_valid` → `rd`/`rd_valid` stable; extra step pulses ignored; raise `rd_ready` → accepted next edge, `pc` increments once.
- Same-edge write `mem[3]`=0xAAAA_AAAA during FETCH of address 3 (old word 0x1111_1111) → `rd`=0x1111_1111; next fetch of address 3 returns 0xAAAA_AAAA.
- Assert `rst` during RESOLVE → `rd_valid`=0, `pc`=0, all words 0; next step fetch returns 0.
